// File: rtl/upsampler_pkg.sv
// Shared defaults and types for the zero-stuffing / hold upsampler.
package upsampler_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FACTOR_DEF = 6;
    localparam int PHASE_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/upsampler_fifo2.sv
// Two-entry FIFO buffering low-rate samples ahead of the interpolator.
// Push is ignored when full and pop when empty; push+pop together keeps count.
module upsampler_fifo2
    import upsampler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign data_out = mem[rd_ptr];

    // Storage, pointers and occupancy; reset flushes everything.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/upsampler_interp.sv
// Integer-ratio upsampler: each input sample yields FACTOR output samples.
// Phase 0 carries the sample; later phases are zero, or repeat the sample
// when UPSAMPLER_HOLD_EN is defined (zero-order hold). Timing is the same
// in both builds. underrun latches whenever the output stream has to stop
// because no next sample was waiting at the end of a period.
module upsampler_interp
    import upsampler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FACTOR = FACTOR_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  up_data_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PHASE_W-1:0] phase,
    output logic               underrun
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(FACTOR - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              out_fire;
    logic              last_fire;

    assign in_ready  = (fifo_count < 2'd2);
    assign out_fire  = out_valid & out_ready;
    assign last_fire = out_fire & (phase == LAST_PHASE);

    upsampler_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push     (in_valid & ~fifo_full),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, FIFO pop and out_valid; a waiting sample is taken at the
    // end of a period so consecutive periods run without a bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (last_fire) begin
                    if (!fifo_empty) pop       = 1'b1;
                    else             state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Current sample, output phase counter and sticky underrun flag.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            phase    <= '0;
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                cur   <= fifo_head;
                phase <= '0;
            end else if (last_fire) begin
                phase <= '0;
            end else if (out_fire) begin
                phase <= phase + 1'b1;
            end
            if (state == EMIT && last_fire && fifo_empty)
                underrun <= 1'b1;
        end
    end

    // Output sample: held registers keep it stable while out_ready is low.
    always_comb begin
`ifdef UPSAMPLER_HOLD_EN
        up_data_out = out_valid ? cur : '0;
`else
        up_data_out = (out_valid && phase == '0) ? cur : '0;
`endif
    end

endmodule
